// File: rtl/tp_pkg.sv
// Shared types and width helpers for the transpose read controller.
package tp_pkg;

  typedef enum logic {
    MODE_COL = 1'b0,
    MODE_ROW = 1'b1
  } rd_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  // Counter width that stays legal for a dimension of 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter widths for the default 64 x 2400 frame geometry.
  localparam int ROW_W = $clog2(64);
  localparam int COL_W = $clog2(2400);

endpackage

// File: rtl/tp_lat_pipe.sv
// RD_LAT-deep shift register carrying {valid, sof, eol} alongside the RAM read,
// with a synchronous flush that empties every stage.
module tp_lat_pipe #(
  parameter int DEPTH = 1,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/tp_rd_ctrl.sv
// Frame RAM read controller: column-major (transpose) or row-major readout with sof/eol/done markers.
// Build macro TP_RD_ABORT_EN adds an abort input that cancels the frame in flight.
module tp_rd_ctrl
  import tp_pkg::*;
#(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 32,
  parameter int ROW        = 64,
  parameter int COL        = 2400,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  hold,
`ifdef TP_RD_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  busy,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  dout_sof,
  output logic                  dout_eol,
  output logic                  done,
  output logic                  start_err
);

  // dout_valid is a push-only stream with no ready: a word is taken in every cycle it is
  // high, and throttling happens only on the address side through hold.
  localparam int RW = cnt_w(ROW);
  localparam int CW = cnt_w(COL);
  localparam logic [RW-1:0]         ROW_LAST   = RW'(ROW - 1);
  localparam logic [CW-1:0]         COL_LAST   = CW'(COL - 1);
  localparam logic [ADDR_WIDTH-1:0] COL_STEP   = ADDR_WIDTH'(COL);
  localparam logic [2:0]            DRAIN_DONE = 3'(RD_LAT);
  localparam logic [2:0]            DRAIN_END  = 3'(RD_LAT + 1);

  rd_state_e             state;
  rd_mode_e              mode_q;
  logic                  first_q;
  logic [RW-1:0]         row_cnt, nxt_row;
  logic [CW-1:0]         col_cnt, nxt_col;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic [2:0]            dcnt;
  logic                  rd_sof, rd_eol;
  logic                  at_first, issue, nxt_final, nxt_eol, flush;
  logic                  p_valid, p_sof, p_eol;

`ifdef TP_RD_ABORT_EN
  assign flush = abort && (state != IDLE);
`else
  assign flush = 1'b0;
`endif

  assign busy     = (state != IDLE);
  assign at_first = first_q || (state == IDLE);
  assign issue    = !hold && ((state == RUN) || (state == IDLE && start));

  // Next position from the last issued one; the column-major step is an add of COL, no multiply.
  always_comb begin
    nxt_row  = row_cnt;
    nxt_col  = col_cnt;
    nxt_addr = rd_addr;
    if (at_first) begin
      nxt_row  = '0;
      nxt_col  = '0;
      nxt_addr = '0;
    end else if (mode_q == MODE_COL) begin
      if (row_cnt == ROW_LAST) begin
        nxt_row  = '0;
        nxt_col  = col_cnt + 1'b1;
        nxt_addr = ADDR_WIDTH'(col_cnt) + 1'b1;
      end else begin
        nxt_row  = row_cnt + 1'b1;
        nxt_addr = rd_addr + COL_STEP;
      end
    end else begin
      nxt_addr = rd_addr + 1'b1;
      if (col_cnt == COL_LAST) begin
        nxt_col = '0;
        nxt_row = row_cnt + 1'b1;
      end else begin
        nxt_col = col_cnt + 1'b1;
      end
    end
  end

  assign nxt_final = (nxt_row == ROW_LAST) && (nxt_col == COL_LAST);
  assign nxt_eol   = (mode_q == MODE_COL) ? (nxt_row == ROW_LAST) : (nxt_col == COL_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= MODE_COL;
      first_q   <= 1'b0;
      row_cnt   <= '0;
      col_cnt   <= '0;
      dcnt      <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      rd_sof    <= 1'b0;
      rd_eol    <= 1'b0;
      done      <= 1'b0;
      start_err <= 1'b0;
    end else begin
      rd_en     <= 1'b0;
      rd_sof    <= 1'b0;
      rd_eol    <= 1'b0;
      done      <= 1'b0;
      start_err <= start && busy;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            mode_q  <= rd_mode_e'(mode);
            first_q <= 1'b1;
          end
        end
        DRAIN: begin
          rd_addr <= '0;
          dcnt    <= dcnt + 1'b1;
          if (dcnt == DRAIN_DONE) done <= 1'b1;
          if (dcnt == DRAIN_END) state <= IDLE;
        end
        default: ;
      endcase
      if (issue) begin
        rd_en   <= 1'b1;
        rd_addr <= nxt_addr;
        row_cnt <= nxt_row;
        col_cnt <= nxt_col;
        rd_sof  <= at_first;
        rd_eol  <= nxt_eol;
        first_q <= 1'b0;
        if (nxt_final) begin
          state <= DRAIN;
          dcnt  <= '0;
        end
      end
      if (flush) begin
        state   <= IDLE;
        rd_en   <= 1'b0;
        rd_addr <= '0;
        first_q <= 1'b0;
        done    <= 1'b0;
      end
    end
  end

  tp_lat_pipe #(
    .DEPTH (RD_LAT),
    .W     (3)
  ) u_lat_pipe (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .din   ({rd_en, rd_sof, rd_eol}),
    .dout  ({p_valid, p_sof, p_eol})
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_sof   <= 1'b0;
      dout_eol   <= 1'b0;
    end else begin
      dout_valid <= p_valid && !flush;
      dout_sof   <= p_valid && p_sof && !flush;
      dout_eol   <= p_valid && p_eol && !flush;
      if (p_valid) dout <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_tp_rd_ctrl.sv
// Bench for tp_rd_ctrl: 4x3 frames at RD_LAT=1 (instance a) and RD_LAT=3 (instance b),
// with address and output-word scoreboards fed from a row/column model of the frame.
module tb_tp_rd_ctrl;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int ROW = 4;
  localparam int COL = 3;
  localparam int N   = ROW * COL;
  localparam int EW  = DW + 3;

  logic clk = 1'b0;
  logic rst, rst_b, start, start_b, mode, hold;
`ifdef TP_RD_ABORT_EN
  logic abort;
`endif

  logic          busy_a, rd_en_a, dout_valid_a, dout_sof_a, dout_eol_a, done_a, start_err_a;
  logic [AW-1:0] rd_addr_a;
  logic [DW-1:0] ram_a, dout_a;
  logic          busy_b, rd_en_b, dout_valid_b, dout_sof_b, dout_eol_b, done_b, start_err_b;
  logic [AW-1:0] rd_addr_b;
  logic [DW-1:0] ram_b, dout_b;
  logic [63:0]   outs_a, outs_b;

  logic [EW-1:0] exp_qa[$];
  logic [EW-1:0] exp_qb[$];
  logic [AW-1:0] addr_qa[$];
  logic [AW-1:0] addr_qb[$];

  int errors = 0;
  int checks = 0;
  logic done_qa = 1'b0;
  logic done_qb = 1'b0;

  always #5 clk = ~clk;

  tp_rd_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROW(ROW), .COL(COL), .RD_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .hold(hold),
`ifdef TP_RD_ABORT_EN
    .abort(abort),
`endif
    .busy(busy_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a), .ram_rdata(ram_a),
    .dout(dout_a), .dout_valid(dout_valid_a), .dout_sof(dout_sof_a), .dout_eol(dout_eol_a),
    .done(done_a), .start_err(start_err_a)
  );

  tp_rd_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROW(ROW), .COL(COL), .RD_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .mode(mode), .hold(hold),
`ifdef TP_RD_ABORT_EN
    .abort(1'b0),
`endif
    .busy(busy_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b), .ram_rdata(ram_b),
    .dout(dout_b), .dout_valid(dout_valid_b), .dout_sof(dout_sof_b), .dout_eol(dout_eol_b),
    .done(done_b), .start_err(start_err_b)
  );

  assign outs_a = {17'd0, busy_a, rd_en_a, rd_addr_a, dout_a, dout_valid_a, dout_sof_a,
                   dout_eol_a, done_a, start_err_a};
  assign outs_b = {17'd0, busy_b, rd_en_b, rd_addr_b, dout_b, dout_valid_b, dout_sof_b,
                   dout_eol_b, done_b, start_err_b};

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    return 32'hC0DE_0000 + 32'(a) * 32'd17;
  endfunction

  // RAM models with 1 and 3 cycles of read latency.
  logic [AW-1:0] pa = '0;
  logic [AW-1:0] pb [3];
  always @(posedge clk) begin
    pa    <= rd_addr_a;
    pb[0] <= rd_addr_b;
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign ram_a = ram_word(pa);
  assign ram_b = ram_word(pb[2]);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Expected frame from row/column position; nw limits how many words should be delivered.
  task automatic push_frame(input bit sel, input bit m, input int nw);
    int r, c;
    logic eol;
    logic [AW-1:0] a;
    logic [EW-1:0] e;
    for (int k = 0; k < N; k++) begin
      if (m == 1'b0) begin
        r = k % ROW; c = k / ROW; eol = (r == ROW - 1);
      end else begin
        r = k / COL; c = k % COL; eol = (c == COL - 1);
      end
      a = AW'(r * COL + c);
      e = {(k == N - 1), (k == 0), eol, ram_word(a)};
      if (sel) addr_qb.push_back(a); else addr_qa.push_back(a);
      if (k < nw) begin
        if (sel) exp_qb.push_back(e); else exp_qa.push_back(e);
      end
    end
  endtask

  task automatic start_frame_a(input bit m, input int nw);
    push_frame(1'b0, m, nw);
    mode  = m;
    start = 1'b1;
    cyc();
    start = 1'b0;
    mode  = ~m;
  endtask

  task automatic wait_done(input bit sel);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      smp();
      if (sel ? done_b : done_a) seen = 1'b1;
      else cyc();
    end
    chk(sel ? "b_done_seen" : "a_done_seen", 64'(seen), 64'd1);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rd_en_a) begin
        if (addr_qa.size() == 0) chk("a_extra_rd", 64'(rd_en_a), 64'd0);
        else chk("a_rd_addr", 64'(rd_addr_a), 64'(addr_qa.pop_front()));
      end
      if (dout_valid_a) begin
        if (exp_qa.size() == 0) chk("a_extra_dout", 64'(dout_valid_a), 64'd0);
        else chk("a_dout", 64'({done_a, dout_sof_a, dout_eol_a, dout_a}), 64'(exp_qa.pop_front()));
      end else if (done_a) chk("a_done_without_valid", 64'(done_a), 64'd0);
      if (done_qa) chk("a_busy_after_done", 64'(busy_a), 64'd0);
      done_qa = done_a;
    end
  end

  always @(negedge clk) begin
    if (!rst_b) begin
      if (rd_en_b) begin
        if (addr_qb.size() == 0) chk("b_extra_rd", 64'(rd_en_b), 64'd0);
        else chk("b_rd_addr", 64'(rd_addr_b), 64'(addr_qb.pop_front()));
      end
      if (dout_valid_b) begin
        if (exp_qb.size() == 0) chk("b_extra_dout", 64'(dout_valid_b), 64'd0);
        else chk("b_dout", 64'({done_b, dout_sof_b, dout_eol_b, dout_b}), 64'(exp_qb.pop_front()));
      end else if (done_b) chk("b_done_without_valid", 64'(done_b), 64'd0);
      if (done_qb) chk("b_busy_after_done", 64'(busy_b), 64'd0);
      done_qb = done_b;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rst_b = 1'b1; start = 1'b0; start_b = 1'b0; mode = 1'b0; hold = 1'b0;
`ifdef TP_RD_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) cyc();
    smp();
    chk("a_reset_outputs", outs_a, 64'd0);
    chk("b_reset_outputs", outs_b, 64'd0);
    cyc();
    rst = 1'b0;
    smp();
    chk("a_idle_after_reset", outs_a, 64'd0);

    // Plain frames, column-major then row-major.
    for (int m = 0; m < 2; m++) begin
      cyc();
      start_frame_a(m[0], N);
      for (int i = 0; i < N; i++) begin
        smp();
        chk("a_burst_rd_en", 64'(rd_en_a), 64'd1);
        cyc();
      end
      smp();
      chk("a_after_final_addr", 64'({rd_en_a, rd_addr_a}), 64'd0);
      cyc();
      wait_done(1'b0);
      cyc();
      smp();
      chk("a_frame_busy_low", 64'(busy_a), 64'd0);
      chk("a_frame_drained", 64'(exp_qa.size() + addr_qa.size()), 64'd0);
    end

    // Hold for three cycles after address 6.
    cyc();
    start_frame_a(1'b0, N);
    cyc();
    cyc();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 2) hold = 1'b0;
      smp();
      chk("a_hold_rd_en", 64'(rd_en_a), 64'd0);
      chk("a_hold_addr", 64'(rd_addr_a), 64'd6);
    end
    cyc();
    smp();
    chk("a_hold_resume", 64'({rd_en_a, rd_addr_a}), 64'h109);
    cyc();
    wait_done(1'b0);
    cyc();
    smp();
    chk("a_hold_drained", 64'(exp_qa.size() + addr_qa.size()), 64'd0);

    // Start while busy at address 4, then restart in the cycle busy falls.
    cyc();
    start_frame_a(1'b0, N);
    repeat (5) cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    smp();
    chk("a_start_err_pulse", 64'({busy_a, start_err_a}), 64'h3);
    cyc();
    smp();
    chk("a_start_err_clear", 64'(start_err_a), 64'd0);
    cyc();
    wait_done(1'b0);
    cyc();
    start_frame_a(1'b0, N);
    smp();
    chk("a_restart_addr0", 64'({rd_en_a, rd_addr_a}), 64'h100);
    chk("a_restart_no_err", 64'(start_err_a), 64'd0);
    cyc();
    wait_done(1'b0);
    cyc();
    smp();
    chk("a_restart_drained", 64'(exp_qa.size() + addr_qa.size()), 64'd0);

    // start and hold together in IDLE.
    cyc();
    push_frame(1'b0, 1'b1, N);
    mode = 1'b1; start = 1'b1; hold = 1'b1;
    cyc();
    start = 1'b0;
    smp();
    chk("a_start_hold_busy", 64'({busy_a, rd_en_a}), 64'h2);
    cyc();
    hold = 1'b0;
    smp();
    chk("a_start_hold_waits", 64'(rd_en_a), 64'd0);
    cyc();
    smp();
    chk("a_start_hold_first", 64'({rd_en_a, rd_addr_a}), 64'h100);
    cyc();
    wait_done(1'b0);
    cyc();
    smp();
    chk("a_start_hold_drained", 64'(exp_qa.size() + addr_qa.size()), 64'd0);

`ifdef TP_RD_ABORT_EN
    // Abort at address 5: eight words were already on their way out.
    cyc();
    start_frame_a(1'b0, 8);
    repeat (9) cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    smp();
    chk("a_abort_stop", 64'({busy_a, rd_en_a}), 64'd0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      smp();
      chk("a_abort_quiet", 64'({dout_valid_a, done_a, busy_a}), 64'd0);
    end
    chk("a_abort_words", 64'(exp_qa.size()), 64'd0);
    chk("a_abort_addr_left", 64'(addr_qa.size()), 64'd2);
    addr_qa.delete();
`endif

    // RD_LAT=3: reset at address 7, then a clean frame.
    cyc();
    rst_b = 1'b0;
    cyc();
    push_frame(1'b1, 1'b0, N);
    mode = 1'b0; start_b = 1'b1;
    cyc();
    start_b = 1'b0; mode = 1'b1;
    repeat (6) cyc();
    smp();
    chk("b_at_addr7", 64'({rd_en_b, rd_addr_b}), 64'h107);
    #1;
    rst_b = 1'b1;
    #1;
    chk("b_reset_immediate", outs_b, 64'd0);
    exp_qb.delete();
    addr_qb.delete();
    for (int i = 0; i < 3; i++) begin
      cyc();
      smp();
      chk("b_reset_quiet", outs_b, 64'd0);
    end
    cyc();
    rst_b = 1'b0;
    cyc();
    push_frame(1'b1, 1'b0, N);
    mode = 1'b0; start_b = 1'b1;
    cyc();
    start_b = 1'b0;
    wait_done(1'b1);
    cyc();
    smp();
    chk("b_frame_busy_low", 64'(busy_b), 64'd0);
    chk("b_frame_drained", 64'(exp_qb.size() + addr_qb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tp_rd_ctrl.md
Name: tp_rd_ctrl

Overview:
Parametrised RAM read controller for the matrix-transpose datapath. On a start pulse it reads one ROW x COL frame from the frame RAM, stored row-major at addr = r*COL + c. The frame is read either column-major (transpose) or row-major (linear). RAM data is re-timed to a valid stream with sof/eol/last markers, so the downstream packer needs no address knowledge. It supports stalling, RAM read latency and start-while-busy detection.

Parameters:
ADDR_WIDTH, 18, RAM address width; must satisfy ROW*COL <= 2**ADDR_WIDTH
DATA_WIDTH, 32, RAM word width
ROW, 64, rows per frame, >= 2
COL, 2400, columns per frame, >= 2
RD_LAT, 1, RAM read latency in cycles (rd_en to ram_rdata), 1..4

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle frame start request
mode  in  1  0 = column-major (transpose), 1 = row-major; sampled with start
hold  in  1  stall address issue while high
busy  out  1  frame in progress, including drain
rd_en  out  1  RAM read enable
rd_addr  out  ADDR_WIDTH  RAM read address
ram_rdata  in  DATA_WIDTH  RAM read data
dout  out  DATA_WIDTH  output word (registered copy of ram_rdata)
dout_valid  out  1  dout valid
dout_sof  out  1  first word of frame
dout_eol  out  1  last word of a line (column in mode 0, row in mode 1)
done  out  1  one-cycle pulse, frame fully delivered
start_err  out  1  one-cycle pulse, start received while busy

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counters 0.
- FSM states:
  - IDLE: start -> latch mode, go to RUN, busy=1.
  - RUN: issues reads; after the final address is issued, go to DRAIN.
  - DRAIN: waits RD_LAT cycles, then go to IDLE.
- rd_en/rd_addr are registered. If start is sampled in cycle N, the first rd_en=1 with rd_addr=0 appears in cycle N+1.
- In RUN, one address is issued per cycle when hold=0. When hold=1, rd_en=0 and rd_addr holds its value; in-flight data still arrives.
- Mode 0 addressing:
  - rd_addr advances by COL while row_cnt < ROW-1.
  - At row_cnt == ROW-1, rd_addr becomes col_cnt+1, row_cnt=0, col_cnt++.
  - No multiplier.
- Mode 1 addressing: rd_addr increments by 1. row_cnt/col_cnt track position; col_cnt wraps at COL-1.
- Final address is ROW*COL-1 in both modes. The cycle after it is issued, rd_en=0 and rd_addr=0.
- Output pipeline: valid/sof/eol are delayed through an RD_LAT-stage shift register aligned to ram_rdata, then registered together with dout. Latency from rd_en to dout_valid is RD_LAT+1 cycles.
- Markers:
  - dout_sof is set on the address-0 word.
  - dout_eol is set when the inner counter is at its terminal value: row_cnt == ROW-1 in mode 0, col_cnt == COL-1 in mode 1.
- done is high in the same cycle as the final dout_valid. busy falls in the following cycle.
- start while busy: ignored, start_err pulses, the current frame is unaffected.
- start and hold both high in IDLE: the frame is accepted, but no address is issued until hold=0.
- A start in the cycle busy falls is accepted normally.
- mode changes mid-frame are ignored.
- Reset mid-frame: immediate return to IDLE, pipeline cleared, no done pulse.

Optional Feature:
- Macro: TP_RD_ABORT_EN.
- With the macro defined, an extra input abort (1 bit) is present. abort in RUN or DRAIN moves the FSM to IDLE next cycle:
  - rd_en forced 0
  - valid pipeline flushed, so no further dout_valid
  - done not asserted
  - busy falls the next cycle
  - abort in IDLE is ignored
  - abort and start in the same IDLE cycle: start wins.
- Without the macro, the port does not exist and the frame always completes.

Decomposition:
- Package tp_pkg:
  - rd_mode_e (MODE_COL, MODE_ROW)
  - rd_state_e (IDLE, RUN, DRAIN)
  - ROW_W/COL_W widths computed with $clog2.
- One sub-module, tp_lat_pipe: a parametrised RD_LAT-deep shift register for {valid, sof, eol} with synchronous flush.

Test Plan:
- ROW=4, COL=3, RD_LAT=1, mode=0, start pulse -> rd_addr sequence 0,3,6,9,1,4,7,10,2,5,8,11 on 12 consecutive cycles. dout_eol on the 4th/8th/12th words, sof on the 1st, done coincident with the 12th dout_valid.
- Same configuration, mode=1 -> addresses 0..11 in order. eol on words 3,6,9,12.
- mode=0, hold high for 3 cycles after address 6 -> rd_addr stays 6 with rd_en=0, sequence resumes at 9. Exactly 12 dout_valid, no duplicates.
- start again at address 4 -> start_err one-cycle pulse, sequence unchanged. A start issued the cycle after busy falls -> new frame begins at address 0.
- rst asserted at address 7, RD_LAT=3 -> all outputs 0 immediately, no done. A following start produces a full clean frame.
- TP_RD_ABORT_EN, abort at address 5 -> rd_en 0 next cycle, zero further dout_valid, no done, busy low the next cycle.
